// File: rtl/score_keeper_if.sv
// Score bus shared by the column judges and the score keeper.
// Judges drive the packed per-column deltas and read back the running
// total. The keeper drives the total, the hit streak and the BCD digits
// used by the HEX display drivers.
interface score_keeper_if #(
  parameter int NCOL = 4
);

  logic [8*NCOL-1:0] scorechange;
  logic [7:0]        totalscore;
  logic [7:0]        streak;
  logic              maxed;
  logic [3:0]        bcd_hund;
  logic [3:0]        bcd_tens;
  logic [3:0]        bcd_ones;
  logic              bcd_valid;

  modport master (
    output scorechange,
    input  totalscore,
    input  streak,
    input  maxed,
    input  bcd_hund,
    input  bcd_tens,
    input  bcd_ones,
    input  bcd_valid
  );

  modport slave (
    input  scorechange,
    output totalscore,
    output streak,
    output maxed,
    output bcd_hund,
    output bcd_tens,
    output bcd_ones,
    output bcd_valid
  );

endinterface

// File: rtl/score_keeper.sv
// Score keeper: sums the signed per-column score deltas into a saturating
// 0..255 total, tracks the consecutive-hit streak, and converts the total to
// three BCD digits with a sequential double-dabble engine.
// Reset is asynchronous and active-low.
module score_keeper #(
  parameter int NCOL = 4
) (
  input  logic          clk,
  input  logic          reset,
  score_keeper_if.slave sk
);

  // 11 bits hold any sum of four signed bytes plus a 0..255 total.
  localparam int SUM_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  logic [SUM_W-1:0] delta_sum;
  logic [SUM_W-1:0] next_sum;
  logic [7:0]       next_total;
  logic             total_changed;
  logic             any_neg;
  logic             any_pos;

  logic [7:0]       total_q;
  logic [7:0]       streak_q;

  state_t           state_q;
  logic             pending_q;
  logic [19:0]      shift_q;
  logic [19:0]      dabble_next;
  logic [2:0]       step_q;
  logic [3:0]       hund_q;
  logic [3:0]       tens_q;
  logic [3:0]       ones_q;
  logic             valid_q;

  // Net all column deltas together and flag whether any hit or miss occurred.
  always_comb begin
    delta_sum = '0;
    any_neg   = 1'b0;
    any_pos   = 1'b0;
    for (int i = 0; i < NCOL; i++) begin
      delta_sum = delta_sum + {{(SUM_W-8){sk.scorechange[8*i+7]}}, sk.scorechange[8*i +: 8]};
      any_neg   = any_neg | sk.scorechange[8*i+7];
      any_pos   = any_pos | ((sk.scorechange[8*i +: 8] != 8'h00) & ~sk.scorechange[8*i+7]);
    end
  end

  // Add the net delta to the current total and clamp into 0..255.
  always_comb begin
    next_sum = delta_sum + {{(SUM_W-8){1'b0}}, total_q};
    if (next_sum[SUM_W-1]) begin
      next_total = 8'h00;
    end else if (|next_sum[SUM_W-2:8]) begin
      next_total = 8'hFF;
    end else begin
      next_total = next_sum[7:0];
    end
    total_changed = (next_total != total_q);
  end

  // Total register plus the hit streak: a miss anywhere clears it, otherwise a cycle with any hit counts once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_q  <= 8'h00;
      streak_q <= 8'h00;
    end else begin
      total_q <= next_total;
      if (any_neg) begin
        streak_q <= 8'h00;
      end else if (any_pos && (streak_q != 8'hFF)) begin
        streak_q <= streak_q + 8'd1;
      end
    end
  end

  // One double-dabble step: bump BCD nibbles of 5 or more by 3, then shift left.
  always_comb begin
    dabble_next = shift_q;
    for (int n = 0; n < 3; n++) begin
      if (dabble_next[8+4*n +: 4] >= 4'd5) begin
        dabble_next[8+4*n +: 4] = dabble_next[8+4*n +: 4] + 4'd3;
      end
    end
    dabble_next = dabble_next << 1;
  end

  // Conversion sequencer; a new total seen mid-conversion leaves pending set so a follow-up run picks up the latest value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      shift_q   <= '0;
      step_q    <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          shift_q   <= {12'b0, total_q};
          pending_q <= 1'b0;
          step_q    <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          shift_q <= dabble_next;
          step_q  <= step_q + 3'd1;
          if (step_q == 3'd7) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          hund_q  <= shift_q[19:16];
          tens_q  <= shift_q[15:12];
          ones_q  <= shift_q[11:8];
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (total_changed) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign sk.totalscore = total_q;
  assign sk.streak     = streak_q;
  assign sk.maxed      = (total_q == 8'hFF);
  assign sk.bcd_hund   = hund_q;
  assign sk.bcd_tens   = tens_q;
  assign sk.bcd_ones   = ones_q;
  assign sk.bcd_valid  = valid_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: a table of delta vectors with
// expected total/streak, a scoreboard queue of expected BCD digits popped
// on every bcd_valid pulse, and hand-written multi-cycle sequences.
module tb_score_keeper;

  logic clk;
  logic reset;

  int checks;
  int failures;
  int valid_count;

  typedef struct {
    logic [31:0] deltas;
    int          exp_total;
    int          exp_streak;
    string       name;
  } vec_t;

  typedef struct {
    int h;
    int t;
    int o;
  } digits_t;

  digits_t sb[$];
  digits_t mon_e;
  vec_t    vecs[19];

  score_keeper_if #(.NCOL(4)) bus();

  score_keeper #(.NCOL(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sk    (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic pushDigits(input int value);
    digits_t d;
    d.h = value / 100;
    d.t = (value / 10) % 10;
    d.o = value % 10;
    sb.push_back(d);
  endtask

  // Drive one cycle of deltas starting from a negedge; returns at the next negedge.
  task automatic applyStimulus(input logic [31:0] deltas);
    bus.scorechange = deltas;
    @(negedge clk);
    bus.scorechange = '0;
  endtask

  task automatic checkState(input string name, input int exp_total, input int exp_streak);
    checkOutput({name, "_total"}, int'(bus.totalscore), exp_total);
    checkOutput({name, "_streak"}, int'(bus.streak), exp_streak);
    checkOutput({name, "_maxed"}, int'(bus.maxed), (exp_total == 255) ? 1 : 0);
  endtask

  // Wait (bounded) for bcd_valid; n reports how many negedges were waited.
  task automatic waitValid(input string name, output int n);
    n = 0;
    while (!bus.bcd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_seen"}, int'(bus.bcd_valid), 1);
  endtask

  // Scoreboard consumer: every bcd_valid pulse must match the oldest expected digits.
  always @(negedge clk) begin
    if (reset && bus.bcd_valid) begin
      valid_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL bcd_unexpected actual=%0d/%0d/%0d expected=no_pulse",
                 bus.bcd_hund, bus.bcd_tens, bus.bcd_ones);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("bcd_hund", int'(bus.bcd_hund), mon_e.h);
        checkOutput("bcd_tens", int'(bus.bcd_tens), mon_e.t);
        checkOutput("bcd_ones", int'(bus.bcd_ones), mon_e.o);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int n2;
    int prev_total;
    int snap;

    checks      = 0;
    failures    = 0;
    valid_count = 0;
    bus.scorechange = '0;

    vecs[0]  = '{32'h0000_0005, 7,   2, "add5"};
    vecs[1]  = '{32'h0A00_0A00, 27,  3, "two_cols"};
    vecs[2]  = '{32'h0000_00FB, 22,  0, "miss5"};
    vecs[3]  = '{32'h7F7F_7F7F, 255, 1, "clamp_hi"};
    vecs[4]  = '{32'h0000_0001, 255, 2, "held_max"};
    vecs[5]  = '{32'h8080_8080, 0,   0, "clamp_lo"};
    vecs[6]  = '{32'h0000_0000, 0,   0, "idle"};
    vecs[7]  = '{32'h0000_0064, 100, 1, "add100"};
    vecs[8]  = '{32'h0019_0019, 150, 2, "add50"};
    vecs[9]  = '{32'hFF00_0001, 150, 0, "netzero"};
    vecs[10] = '{32'h0000_0000, 150, 0, "idle2"};
    vecs[11] = '{32'h0000_0068, 254, 1, "to254"};
    vecs[12] = '{32'h0000_0102, 255, 2, "to255"};
    vecs[13] = '{32'h0000_8082, 1,   0, "to1"};
    vecs[14] = '{32'h0000_0001, 2,   1, "to2"};
    vecs[15] = '{32'h0001_0000, 3,   2, "to3"};
    vecs[16] = '{32'h00FC_0000, 0,   0, "under0"};
    vecs[17] = '{32'h0000_0028, 40,  1, "to40"};
    vecs[18] = '{32'h0000_FE02, 40,  0, "mix40"};

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkState("reset", 0, 0);
    checkOutput("reset_hund", int'(bus.bcd_hund), 0);
    checkOutput("reset_tens", int'(bus.bcd_tens), 0);
    checkOutput("reset_ones", int'(bus.bcd_ones), 0);
    checkOutput("reset_valid", int'(bus.bcd_valid), 0);
    reset = 1'b1;
    @(negedge clk);

    // First delta and conversion latency
    $display("[TB] first delta and latency");
    pushDigits(2);
    applyStimulus(32'h0000_0002);
    checkState("first", 2, 1);
    waitValid("first_valid", n);
    checkOutput("first_latency", n, 11);
    repeat (5) @(negedge clk);
    checkOutput("first_drain", sb.size(), 0);

    // Table-driven accumulation, clamping and streak vectors
    $display("[TB] vector table");
    prev_total = 2;
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].exp_total != prev_total) begin
        pushDigits(vecs[i].exp_total);
      end
      applyStimulus(vecs[i].deltas);
      checkState(vecs[i].name, vecs[i].exp_total, vecs[i].exp_streak);
      prev_total = vecs[i].exp_total;
      repeat (14) @(negedge clk);
      checkOutput({vecs[i].name, "_drain"}, sb.size(), 0);
    end

    // Net-zero deltas start no conversion
    $display("[TB] net-zero no conversion");
    snap = valid_count;
    applyStimulus(32'h0303_FDFD);
    checkState("netzero40", 40, 0);
    repeat (20) @(negedge clk);
    checkOutput("netzero_pulses", valid_count - snap, 0);

    // Change mid-conversion: current run completes, then a follow-up run
    $display("[TB] change mid-conversion");
    snap = valid_count;
    pushDigits(17);
    pushDigits(19);
    applyStimulus(32'h0000_00E9);
    checkState("to17", 17, 0);
    repeat (6) @(negedge clk);
    applyStimulus(32'h0000_0002);
    checkState("to19", 19, 1);
    waitValid("mid_first", n);
    @(negedge clk);
    waitValid("mid_second", n2);
    checkOutput("mid_gap", n2 + 1, 11);
    repeat (20) @(negedge clk);
    checkOutput("mid_pulses", valid_count - snap, 2);
    checkOutput("mid_drain", sb.size(), 0);

    // Several changes during one conversion: one follow-up with the latest value
    $display("[TB] multiple changes merge");
    snap = valid_count;
    pushDigits(20);
    pushDigits(22);
    applyStimulus(32'h0000_0001);
    repeat (3) @(negedge clk);
    applyStimulus(32'h0000_0001);
    repeat (2) @(negedge clk);
    applyStimulus(32'h0000_0001);
    checkState("to22", 22, 4);
    repeat (30) @(negedge clk);
    checkOutput("merge_pulses", valid_count - snap, 2);
    checkOutput("merge_drain", sb.size(), 0);

    // Asynchronous reset mid-conversion
    $display("[TB] reset mid-conversion");
    applyStimulus(32'h0000_0003);
    checkState("to25", 25, 5);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkState("async_reset", 0, 0);
    checkOutput("async_hund", int'(bus.bcd_hund), 0);
    checkOutput("async_tens", int'(bus.bcd_tens), 0);
    checkOutput("async_ones", int'(bus.bcd_ones), 0);
    checkOutput("async_valid", int'(bus.bcd_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    snap = valid_count;
    repeat (20) @(negedge clk);
    checkOutput("abort_pulses", valid_count - snap, 0);
    pushDigits(1);
    applyStimulus(32'h0000_0001);
    checkState("after_reset", 1, 1);
    repeat (14) @(negedge clk);
    checkOutput("after_reset_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
